// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: word width, NOP encoding,
// default reset vector, fetch FSM states and the instruction FIFO entry.
package mips_pkg;

  localparam int          WORD_W           = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // FETCH: no wrong-path responses pending; FLUSH: dropping stale responses.
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  // One delivered instruction as presented to the IF/ID register.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with clear. Pushes while full and pops while
// empty are ignored; clear wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == (AW+1)'(0));
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      count_d  = (AW+1)'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head never shows stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= W'(0);
      end
    end else if (do_push_s && !clear_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word requests under a
// credit limit (FIFO occupancy + outstanding < DEPTH), pairs in-order
// responses with their request PC through a tag queue, and drops responses
// belonging to a path abandoned by a redirect.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instruction
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  fetch_state_e  state_q, state_d;
  logic          reset_cycle_q;

  logic          accept_s, drop_s, deliver_s, pop_s, credit_s;
  logic [CW:0]   inflight_s;

  fetch_entry_t  push_entry_s, head_entry_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;

  logic [31:0]   tag_head_s;
  logic          tag_full_s, tag_empty_s;
  logic [CW-1:0] tag_count_s;
  logic          unused_s;

  // Credit: delivered-but-unconsumed plus requested-but-unreturned stays
  // within DEPTH, so a stalled consumer can never overflow the FIFO.
  assign inflight_s     = {1'b0, fifo_count_s} + {1'b0, outstanding_q};
  assign credit_s       = (inflight_s < (CW+1)'(DEPTH));
  assign imem_req_valid = !reset_cycle_q && !redirect_valid && credit_s;
  assign imem_req_addr  = pc_q;
  assign accept_s       = imem_req_valid && imem_req_ready;

  // Responses are dropped while flushing; otherwise delivered unless a
  // redirect in this very cycle makes them wrong-path.
  assign drop_s         = imem_resp_valid && (state_q == FLUSH);
  assign deliver_s      = imem_resp_valid && (state_q == FETCH) && !redirect_valid;
  assign pop_s          = if_valid && !stall && !redirect_valid;

  assign push_entry_s.instr    = imem_resp_data;
  assign push_entry_s.pc_plus4 = tag_head_s + 32'd4;

  assign if_valid       = !fifo_empty_s;
  assign if_pc_plus4    = if_valid ? head_entry_s.pc_plus4 : 32'h0000_0000;
  assign if_instruction = if_valid ? head_entry_s.instr : NOP_INSTR;

  assign unused_s = ^{fifo_full_s, tag_full_s, tag_empty_s, tag_count_s};

  fetch_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (redirect_valid),
    .push_i  (deliver_s),
    .pop_i   (pop_s),
    .data_i  (push_entry_s),
    .data_o  (head_entry_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  fetch_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (redirect_valid),
    .push_i  (accept_s),
    .pop_i   (deliver_s),
    .data_i  (pc_q),
    .data_o  (tag_head_s),
    .full_o  (tag_full_s),
    .empty_o (tag_empty_s),
    .count_o (tag_count_s)
  );

  // PC, outstanding/discard accounting and FSM next state.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    state_d       = state_q;

    case ({accept_s, imem_resp_valid})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect_valid) begin
      pc_d      = word_align(redirect_pc);
      discard_d = outstanding_d;
    end else begin
      if (accept_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      if (drop_s) begin
        discard_d = discard_q - CW'(1);
      end else begin
        discard_d = discard_q;
      end
    end

    case (state_q)
      FETCH: begin
        if (redirect_valid && (outstanding_d != CW'(0))) begin
          state_d = FLUSH;
        end else begin
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (discard_d == CW'(0)) begin
          state_d = FETCH;
        end else begin
          state_d = FLUSH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State registers; reset_cycle_q masks requests for the cycle after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= word_align(RESET_PC);
      outstanding_q <= CW'(0);
      discard_q     <= CW'(0);
      state_q       <= FETCH;
      reset_cycle_q <= 1'b1;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      state_q       <= state_d;
      reset_cycle_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model of
// configurable latency. Instruction word at address A is ~A.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instruction;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] pop_pc4[$];
  logic [31:0] pop_ins[$];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .if_valid        (if_valid),
    .if_pc_plus4     (if_pc_plus4),
    .if_instruction  (if_instruction)
  );

  // One clock: sample handshakes before the edge, update memory model and
  // the record of consumed instructions after it.
  task automatic step();
    logic acc, rsp, pop, rst;
    logic [31:0] a, p4, ins;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    rsp = imem_resp_valid;
    pop = if_valid && !stall && !redirect_valid;
    p4  = if_pc_plus4;
    ins = if_instruction;
    rst = !reset;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (rsp && (mq_addr.size() > 0)) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (acc) begin
        mq_addr.push_back(a);
        mq_due.push_back(cyc + lat - 1);
      end
      if (pop) begin
        pop_pc4.push_back(p4);
        pop_ins.push_back(ins);
      end
    end
    if ((mq_addr.size() > 0) && (mq_due[0] <= cyc)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = ~mq_addr[0];
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0000_0000;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    imem_req_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    pop_pc4.delete();
    pop_ins.delete();
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0000_0000;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0000_0000;
    step();
    step();
    total++;
    if ({imem_req_valid, if_valid} !== 2'b00) begin
      $display("FAIL reset_valids got=%b exp=00", {imem_req_valid, if_valid});
      bad++;
    end
    total++;
    if (imem_req_addr !== 32'h0000_0000) begin
      $display("FAIL reset_addr got=%h exp=00000000", imem_req_addr);
      bad++;
    end
    total++;
    if ({if_pc_plus4, if_instruction} !== 64'h0) begin
      $display("FAIL reset_if_out got=%h/%h exp=0/0", if_pc_plus4, if_instruction);
      bad++;
    end
    reset = 1'b1;
    step();
    total++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_0000}) begin
      $display("FAIL reset_first_req got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr);
      bad++;
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      total++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'(4 * k)}) begin
        $display("FAIL stream_req k=%0d got=%b/%h exp=1/%h", k, imem_req_valid, imem_req_addr, 32'(4 * k));
        bad++;
      end
      if (k < 2) begin
        total++;
        if (if_valid !== 1'b0) begin
          $display("FAIL stream_early_valid k=%0d got=%b exp=0", k, if_valid);
          bad++;
        end
      end
      if (k == 2) begin
        total++;
        if ({if_valid, if_pc_plus4, if_instruction} !== {1'b1, 32'h4, 32'hFFFF_FFFF}) begin
          $display("FAIL stream_first got=%b/%h/%h exp=1/4/ffffffff", if_valid, if_pc_plus4, if_instruction);
          bad++;
        end
      end
      step();
    end
    total++;
    if (pop_pc4.size() !== 8) begin
      $display("FAIL stream_count got=%0d exp=8", pop_pc4.size());
      bad++;
    end
    for (int i = 0; i < pop_pc4.size(); i++) begin
      total++;
      if ({pop_pc4[i], pop_ins[i]} !== {32'(4 * (i + 1)), ~32'(4 * i)}) begin
        $display("FAIL stream_data i=%0d got=%h/%h exp=%h/%h", i, pop_pc4[i], pop_ins[i], 32'(4 * (i + 1)), ~32'(4 * i));
        bad++;
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat = 1;
    step();
    step();
    stall = 1'b1;
    repeat (6) step();
    total++;
    if ({imem_req_valid, if_valid, if_pc_plus4} !== {1'b0, 1'b1, 32'h4}) begin
      $display("FAIL stall_hold got=%b/%b/%h exp=0/1/4", imem_req_valid, if_valid, if_pc_plus4);
      bad++;
    end
    total++;
    if (pop_pc4.size() !== 0) begin
      $display("FAIL stall_no_pop got=%0d exp=0", pop_pc4.size());
      bad++;
    end
    stall = 1'b0;
    repeat (12) step();
    total++;
    if (pop_pc4.size() !== 12) begin
      $display("FAIL stall_release_count got=%0d exp=12", pop_pc4.size());
      bad++;
    end
    for (int i = 0; i < pop_pc4.size(); i++) begin
      total++;
      if (pop_pc4[i] !== 32'(4 * (i + 1))) begin
        $display("FAIL stall_order i=%0d got=%h exp=%h", i, pop_pc4[i], 32'(4 * (i + 1)));
        bad++;
      end
    end
  endtask

  task automatic test_reset_full();
    do_reset();
    lat = 1;
    step();
    step();
    stall = 1'b1;
    repeat (6) step();
    reset = 1'b0;
    step();
    total++;
    if ({if_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b0, 32'h0000_0000}) begin
      $display("FAIL rstfull_ctl got=%b/%b/%h exp=0/0/00000000", if_valid, imem_req_valid, imem_req_addr);
      bad++;
    end
    total++;
    if ({if_pc_plus4, if_instruction} !== 64'h0) begin
      $display("FAIL rstfull_out got=%h/%h exp=0/0", if_pc_plus4, if_instruction);
      bad++;
    end
    reset = 1'b1;
    stall = 1'b0;
    step();
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 3;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    total++;
    if (imem_req_valid !== 1'b0) begin
      $display("FAIL redir_req_blocked got=%b exp=0", imem_req_valid);
      bad++;
    end
    step();
    redirect_valid = 1'b0;
    #1;
    total++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_0100}) begin
      $display("FAIL redir_new_addr got=%b/%h exp=1/00000100", imem_req_valid, imem_req_addr);
      bad++;
    end
    repeat (10) step();
    total++;
    if (pop_pc4.size() < 2) begin
      $display("FAIL redir_count got=%0d exp>=2", pop_pc4.size());
      bad++;
    end else if ({pop_pc4[0], pop_ins[0], pop_pc4[1]} !== {32'h104, 32'hFFFF_FEFF, 32'h108}) begin
      $display("FAIL redir_first got=%h/%h/%h exp=104/fffffeff/108", pop_pc4[0], pop_ins[0], pop_pc4[1]);
      bad++;
    end
  endtask

  task automatic test_redirect_resp();
    do_reset();
    lat = 2;
    step();
    step();
    step();
    total++;
    if ({if_valid, if_pc_plus4} !== {1'b1, 32'h4}) begin
      $display("FAIL rr_head got=%b/%h exp=1/4", if_valid, if_pc_plus4);
      bad++;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    total++;
    if (imem_req_valid !== 1'b0) begin
      $display("FAIL rr_req_blocked got=%b exp=0", imem_req_valid);
      bad++;
    end
    step();
    redirect_valid = 1'b0;
    #1;
    total++;
    if ({if_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h0000_0200}) begin
      $display("FAIL rr_after got=%b/%b/%h exp=0/1/00000200", if_valid, imem_req_valid, imem_req_addr);
      bad++;
    end
    total++;
    if (pop_pc4.size() !== 0) begin
      $display("FAIL rr_no_pop got=%0d exp=0", pop_pc4.size());
      bad++;
    end
    repeat (8) step();
    total++;
    if (pop_pc4.size() < 1) begin
      $display("FAIL rr_count got=%0d exp>=1", pop_pc4.size());
      bad++;
    end else if (pop_pc4[0] !== 32'h204) begin
      $display("FAIL rr_first got=%h exp=00000204", pop_pc4[0]);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 3;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_pc = 32'h0000_0300;
    #1;
    total++;
    if (imem_req_valid !== 1'b0) begin
      $display("FAIL b2b_req_blocked got=%b exp=0", imem_req_valid);
      bad++;
    end
    step();
    redirect_valid = 1'b0;
    #1;
    total++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_0300}) begin
      $display("FAIL b2b_addr got=%b/%h exp=1/00000300", imem_req_valid, imem_req_addr);
      bad++;
    end
    repeat (10) step();
    total++;
    if (pop_pc4.size() < 1) begin
      $display("FAIL b2b_count got=%0d exp>=1", pop_pc4.size());
      bad++;
    end else if ({pop_pc4[0], pop_ins[0]} !== {32'h304, 32'hFFFF_FCFF}) begin
      $display("FAIL b2b_first got=%h/%h exp=304/fffffcff", pop_pc4[0], pop_ins[0]);
      bad++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    #1;
    total++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      $display("FAIL wrap_addr0 got=%b/%h exp=1/fffffffc", imem_req_valid, imem_req_addr);
      bad++;
    end
    step();
    total++;
    if (imem_req_addr !== 32'h0000_0000) begin
      $display("FAIL wrap_addr1 got=%h exp=00000000", imem_req_addr);
      bad++;
    end
    repeat (5) step();
    total++;
    if (pop_pc4.size() < 2) begin
      $display("FAIL wrap_count got=%0d exp>=2", pop_pc4.size());
      bad++;
    end else if ({pop_pc4[0], pop_ins[0], pop_pc4[1]} !== {32'h0, 32'h3, 32'h4}) begin
      $display("FAIL wrap_data got=%h/%h/%h exp=0/3/4", pop_pc4[0], pop_ins[0], pop_pc4[1]);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_reset_full();
    test_redirect();
    test_redirect_resp();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
